// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: pixel-tick divider, h/v counters, addresses and
// latency-compensated sync/DE/RGB. Define VGA_TEST_PATTERN_EN to add colour-bar output.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned RGB_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3*RGB_W-1:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               pattern_sel,
`endif
    output logic               pix_ce,
    output logic [11:0]        addr_h,
    output logic [11:0]        addr_v,
    output logic               addr_vld,
    output logic               frame_start,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic [RGB_W-1:0]   rgb_r,
    output logic [RGB_W-1:0]   rgb_g,
    output logic [RGB_W-1:0]   rgb_b
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DLY_W    = 15;
`else
    localparam int unsigned DLY_W    = 3;
`endif

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (PIPE_LAT > 8) begin : g_bad_lat
        $error("vga_timing_gen: PIPE_LAT must be <= 8");
    end
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 4096");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               pix_ce_q, pix_ce_d;
    logic [11:0]        h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic               h_last, v_last;
    logic               vld_c, hs_c, vs_c;
    logic [11:0]        addr_h_q, addr_v_q;
    logic               addr_vld_q, frame_start_q;
    logic               h_sync_q, v_sync_q, de_q;
    logic [3*RGB_W-1:0] rgb_q, pix_w;
    logic [DLY_W-1:0]   raw_w, tap_w;

    // pix_ce is registered so it is 0 in reset and high exactly while div_cnt == CLK_DIV-1.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        pix_ce_d  = (div_cnt_d == DIV_LAST);
    end

    always_comb begin
        h_last  = (h_cnt_q == 12'(H_TOTAL - 1));
        v_last  = (v_cnt_q == 12'(V_TOTAL - 1));
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_ce_q) begin
            h_cnt_d = h_last ? 12'd0 : h_cnt_q + 12'd1;
            if (h_last) begin
                v_cnt_d = v_last ? 12'd0 : v_cnt_q + 12'd1;
            end
        end
    end

    always_comb begin
        vld_c = ({1'b0, h_cnt_q} < 13'(H_ACTIVE)) && ({1'b0, v_cnt_q} < 13'(V_ACTIVE));
        hs_c  = ({1'b0, h_cnt_q} >= 13'(HS_START)) && ({1'b0, h_cnt_q} < 13'(HS_END));
        vs_c  = ({1'b0, v_cnt_q} >= 13'(VS_START)) && ({1'b0, v_cnt_q} < 13'(VS_END));
`ifdef VGA_TEST_PATTERN_EN
        raw_w = {(vld_c ? h_cnt_q : 12'd0), vld_c, vs_c, hs_c};
`else
        raw_w = {vld_c, vs_c, hs_c};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q     <= '0;
            pix_ce_q      <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            addr_h_q      <= '0;
            addr_v_q      <= '0;
            addr_vld_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_ce_q      <= pix_ce_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= pix_ce_q && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
            if (pix_ce_q) begin
                addr_vld_q <= vld_c;
                addr_h_q   <= vld_c ? h_cnt_q : 12'd0;
                addr_v_q   <= vld_c ? v_cnt_q : 12'd0;
            end
        end
    end

    // Entry k holds the counter-derived word from k+1 ticks ago; the output register then
    // lands it exactly PIPE_LAT ticks after the matching address.
    if (PIPE_LAT == 0) begin : g_no_dly
        assign tap_w = raw_w;
    end else begin : g_dly
        logic [DLY_W-1:0] dly_q [PIPE_LAT];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < PIPE_LAT; i++) begin
                    dly_q[i] <= '0;
                end
            end else if (pix_ce_q) begin
                dly_q[0] <= raw_w;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign tap_w = dly_q[PIPE_LAT-1];
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [14:0] bar_w;
    logic [2:0]  bar_idx;

    // Bars in order white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        bar_w   = {tap_w[14:3], 3'b000} / 15'(H_ACTIVE);
        bar_idx = bar_w[2:0];
        if (pattern_sel) begin
            pix_w = {{RGB_W{~bar_idx[1]}}, {RGB_W{~bar_idx[2]}}, {RGB_W{~bar_idx[0]}}};
        end else begin
            pix_w = rgb_in;
        end
    end
`else
    assign pix_w = rgb_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_sync_q <= ~H_POL;
            v_sync_q <= ~V_POL;
            de_q     <= 1'b0;
            rgb_q    <= '0;
        end else if (pix_ce_q) begin
            h_sync_q <= tap_w[0] ? H_POL : ~H_POL;
            v_sync_q <= tap_w[1] ? V_POL : ~V_POL;
            de_q     <= tap_w[2];
            rgb_q    <= tap_w[2] ? pix_w : '0;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign addr_h      = addr_h_q;
    assign addr_v      = addr_v_q;
    assign addr_vld    = addr_vld_q;
    assign frame_start = frame_start_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign de          = de_q;
    assign rgb_r       = rgb_q[3*RGB_W-1 -: RGB_W];
    assign rgb_g       = rgb_q[2*RGB_W-1 -: RGB_W];
    assign rgb_b       = rgb_q[RGB_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small raster (15x8 ticks, CLK_DIV=3, PIPE_LAT=2)
// plus a CLK_DIV=1, active-high-sync instance checked by per-frame counts.
module tb_vga_timing_gen;

    localparam int unsigned DIV = 3;
    localparam int unsigned HT  = 15;
    localparam int unsigned VT  = 8;

    typedef struct {
        logic [11:0] ah;
        logic [11:0] av;
        logic        vld;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
    } exp_t;

    exp_t q[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mon_en = 1'b0;
    logic [11:0] src_q;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        pix_ce, addr_vld, frame_start, h_sync, v_sync, de;
    logic [11:0] addr_h, addr_v;
    logic [3:0]  rgb_r, rgb_g, rgb_b;

    logic        pix_ce2, addr_vld2, frame_start2, h_sync2, v_sync2, de2;
    logic [11:0] addr_h2, addr_v2;
    logic [3:0]  rgb_r2, rgb_g2, rgb_b2;

    vga_timing_gen #(
        .CLK_DIV(DIV), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .PIPE_LAT(2), .RGB_W(4)
    ) u_dut (
        .clk(clk), .rst(rst), .rgb_in(src_q),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .pix_ce(pix_ce), .addr_h(addr_h), .addr_v(addr_v), .addr_vld(addr_vld),
        .frame_start(frame_start), .h_sync(h_sync), .v_sync(v_sync), .de(de),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_LAT(0), .RGB_W(4)
    ) u_dut2 (
        .clk(clk), .rst(rst), .rgb_in(12'hFFF),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .pix_ce(pix_ce2), .addr_h(addr_h2), .addr_v(addr_v2), .addr_vld(addr_vld2),
        .frame_start(frame_start2), .h_sync(h_sync2), .v_sync(v_sync2), .de(de2),
        .rgb_r(rgb_r2), .rgb_g(rgb_g2), .rgb_b(rgb_b2)
    );

    initial forever #5 clk = ~clk;

    // Pixel source whose data is ready by the second tick after the address.
    always @(posedge clk) begin
        if (pix_ce) src_q <= {addr_h[3:0], addr_v[3:0], 4'hA};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected outputs after the n-th pixel tick following reset release.
    function automatic exp_t exp_at(input int n);
        exp_t e;
        int h, v, hm, vm, m;
        h = n % HT;
        v = (n / HT) % VT;
        e.vld = (h < 8) && (v < 4);
        e.ah  = e.vld ? 12'(h) : 12'd0;
        e.av  = e.vld ? 12'(v) : 12'd0;
        e.fs  = (h == 0) && (v == 0);
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        e.de  = 1'b0;
        e.rgb = 12'd0;
        if (n >= 2) begin
            m  = n - 2;
            hm = m % HT;
            vm = (m / HT) % VT;
            e.hs  = !((hm >= 10) && (hm < 13));
            e.vs  = !((vm >= 5) && (vm < 7));
            e.de  = (hm < 8) && (vm < 4);
            e.rgb = e.de ? {4'(hm), 4'(vm), 4'hA} : 12'd0;
        end
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_pix_ce"}, pix_ce, 0);
        check({tag, "_addr"}, {addr_h, addr_v}, 0);
        check({tag, "_vld_fs"}, {addr_vld, frame_start}, 0);
        check({tag, "_hs_vs"}, {h_sync, v_sync}, 2'b11);
        check({tag, "_de"}, de, 0);
        check({tag, "_rgb"}, {rgb_r, rgb_g, rgb_b}, 0);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (q.size() != 0 && t < budget) begin
            @(posedge clk);
            #2;
            t++;
        end
        mon_en = 1'b0;
        check("scoreboard_drained", q.size(), 0);
    endtask

    // Monitor: compares every stage update against the head of the scoreboard.
    initial begin
        int   gap;
        bit   seen;
        logic ce;
        exp_t e;
        gap  = 0;
        seen = 0;
        forever begin
            @(negedge clk);
            ce = pix_ce;
            if (!mon_en) begin
                seen = 0;
                gap  = 0;
            end else begin
                gap++;
                if (ce) begin
                    if (seen) check("pix_ce_period", gap, DIV);
                    seen = 1;
                    gap  = 0;
                end
            end
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (ce) begin
                    if (q.size() == 0) begin
                        check("scoreboard_underflow", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("addr_h", addr_h, e.ah);
                        check("addr_v", addr_v, e.av);
                        check("addr_vld", addr_vld, e.vld);
                        check("frame_start", frame_start, e.fs);
                        check("h_sync", h_sync, e.hs);
                        check("v_sync", v_sync, e.vs);
                        check("de", de, e.de);
                        check("rgb", {rgb_r, rgb_g, rgb_b}, e.rgb);
                    end
                end else begin
                    check("frame_start_width", frame_start, 0);
                end
            end
        end
    end

    initial begin
        int hs_n, vs_n, de_n, ce_n, t;
        repeat (3) @(posedge clk);
        #3;
        check_reset_vals("por");

        // Run 1: a bit more than one frame from reset.
        for (int n = 0; n < 130; n++) q.push_back(exp_at(n));
        rst    = 1'b0;
        mon_en = 1'b1;

        // Second instance: CLK_DIV=1, active-high syncs, no latency, over two 77-tick frames.
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!pix_ce2 && t < 10);
        check("dut2_first_ce", pix_ce2, 1);
        hs_n = 0; vs_n = 0; de_n = 0; ce_n = 0;
        for (int i = 0; i < 154; i++) begin
            @(posedge clk);
            #1;
            hs_n += int'(h_sync2);
            vs_n += int'(v_sync2);
            de_n += int'(de2);
            ce_n += int'(pix_ce2);
        end
        check("dut2_hsync_high_ticks", hs_n, 14);
        check("dut2_vsync_high_ticks", vs_n, 22);
        check("dut2_de_ticks", de_n, 64);
        check("dut2_pix_ce_ticks", ce_n, 154);

        drain(1000);

        // Mid-operation reset between clock edges.
        repeat (20) @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_reset_vals("async_rst");
        q.delete();
        repeat (3) @(posedge clk);
        #3;

        // Run 2: restart at (0,0) and cover two full frames and a wrap.
        for (int n = 0; n < 250; n++) q.push_back(exp_at(n));
        rst    = 1'b0;
        mon_en = 1'b1;
        drain(1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
